alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_issue_ctrl_if.sv | 25 ++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode encodings,
// FSM state encoding and status-word bit positions.
package alu_pkg;

  // Opcodes presented to the downstream ALU on alu_op
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Status word layout {C,Z,V,N}
  localparam int ST_C = 3;
  localparam int ST_Z = 2;
  localparam int ST_V = 1;
  localparam int ST_N = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPER = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Assemble the four ALU flags into status-word order
  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic v, input logic n);
    logic [3:0] f;
    f       = '0;
    f[ST_C] = c;
    f[ST_Z] = z;
    f[ST_V] = v;
    f[ST_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command channel of the ALU issue controller: valid/ready handshake plus
// the command fields. The master issues commands, the slave accepts them.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [RW-1:0]    cmd_rd;
  logic [RW-1:0]    cmd_rs1;
  logic [RW-1:0]    cmd_rs2;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_load, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_load, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// Register file for the ALU issue controller: one synchronous write port,
// three combinational read ports (two operand reads and a debug read).
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int RW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [RW-1:0]    rs1_addr,
  input  logic [RW-1:0]    rs2_addr,
  input  logic [RW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem [NREG];

  // Reset clears every entry and takes priority over a pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = mem[rs1_addr];
  assign rs2_data = mem[rs2_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one command at a time, fetches operands
// from the register file, drives an external ALU, captures its result and
// flags, then writes back and updates the status word.
// Optional feature: define ALU_ISSUE_STICKY_V_EN to enable the sticky
// overflow flag (v_sticky / clr_sticky); otherwise v_sticky reads 0.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  NREG  = 4,
  localparam int RW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic [3:0]       status,
  output logic             done,
  output logic             busy,
  input  logic [RW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             v_sticky,
  input  logic             clr_sticky
);

  state_t           state;
  logic [2:0]       op_q;
  logic [RW-1:0]    rd_q, rs1_q, rs2_q;
  logic             load_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [2:0]       opop_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] rs1_data, rs2_data;
  logic             wr_en;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .RW    (RW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .wr_addr  (rd_q),
    .wr_data  (res_q),
    .rs1_addr (rs1_q),
    .rs2_addr (rs2_q),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data)
  );

  // Write-back happens at the edge that ends WB; res_q holds the immediate
  // for loads so the regfile sees a single write source.
  assign wr_en         = (state == S_WB);
  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);

  // Operand registers are zero outside EXEC/WB, so the ALU inputs are too
  assign alu_a  = opa_q;
  assign alu_b  = opb_q;
  assign alu_op = opop_q;

  // Issue FSM: latch command, fetch operands, capture ALU, write back
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      load_q  <= 1'b0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opop_q  <= '0;
      res_q   <= '0;
      flags_q <= '0;
      status  <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            rd_q   <= cmd.cmd_rd;
            rs1_q  <= cmd.cmd_rs1;
            rs2_q  <= cmd.cmd_rs2;
            load_q <= cmd.cmd_load;
            imm_q  <= cmd.cmd_imm;
            state  <= S_OPER;
          end
        end
        S_OPER: begin
          // Loads leave the ALU inputs at zero; their operands are don't-care
          if (!load_q) begin
            opa_q  <= rs1_data;
            opb_q  <= rs2_data;
            opop_q <= op_q;
          end
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= load_q ? imm_q : alu_result;
          flags_q <= pack_flags(alu_c, alu_z, alu_v, alu_n);
          done    <= 1'b1;
          state   <= S_WB;
        end
        S_WB: begin
          if (!load_q) status <= flags_q;
          done   <= 1'b0;
          opa_q  <= '0;
          opb_q  <= '0;
          opop_q <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_V_EN
  // Sticky overflow: set by an ALU write-back with V=1, set beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      v_sticky <= 1'b0;
    end else if ((state == S_WB) && !load_q && flags_q[ST_V]) begin
      v_sticky <= 1'b1;
    end else if (clr_sticky) begin
      v_sticky <= 1'b0;
    end
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign v_sticky          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREG  = 4;
  localparam int RW    = 2;
`ifdef ALU_ISSUE_STICKY_V_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_op;
  logic             alu_c, alu_z, alu_v, alu_n;
  logic [3:0]       status;
  logic             done, busy, v_sticky, clr_sticky;
  logic [RW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl_if #(.WIDTH(WIDTH), .RW(RW)) cif ();

  alu_issue_ctrl #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cif.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_n      (alu_n),
    .status     (status),
    .done       (done),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .v_sticky   (v_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  // Downstream ALU model: SUB carry means no borrow (a >= b)
  always_comb begin
    logic [8:0] s;
    s          = '0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_op)
      OP_ADD: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = s[7:0];
        alu_c = s[8];
        alu_v = (alu_a[7] == alu_b[7]) && (s[7] != alu_a[7]);
      end
      OP_SUB: begin
        alu_result = alu_a - alu_b;
        alu_c = (alu_a >= alu_b);
        alu_v = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SHL: begin alu_result = alu_a << 1; alu_c = alu_a[7]; end
      OP_SHR: begin alu_result = alu_a >> 1; alu_c = alu_a[0]; end
      default: alu_result = alu_a;
    endcase
    alu_z = (alu_result == 8'h00);
    alu_n = alu_result[7];
  end

  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] imm;
    logic [7:0] exp_val;
    logic [3:0] exp_stat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic mk(output vec_t v, input logic ld, input logic [2:0] op,
                    input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                    input logic [7:0] imm, input logic [7:0] ev, input logic [3:0] es);
    v.ld = ld; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp_val = ev; v.exp_stat = es;
  endtask

  // Issue one command, scramble the fields after handshake, check done timing,
  // write-back value and status.
  task automatic run_cmd(input vec_t v, input string tag);
    logic [2:0] seen;
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_load = v.ld; cif.cmd_op = v.op;
    cif.cmd_rd = v.rd; cif.cmd_rs1 = v.rs1; cif.cmd_rs2 = v.rs2; cif.cmd_imm = v.imm;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0; cif.cmd_load = ~v.ld; cif.cmd_op = v.op ^ 3'b111;
    cif.cmd_rd = v.rd + 2'd1; cif.cmd_rs1 = v.rs1 + 2'd1; cif.cmd_rs2 = v.rs2 + 2'd2;
    cif.cmd_imm = ~v.imm;
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      seen[k] = done;
    end
    chk({tag, "_done_timing"}, seen, 3'b010);
    dbg_addr = v.rd; #1;
    chk({tag, "_rd_value"}, dbg_data, v.exp_val);
    chk({tag, "_status"}, status, v.exp_stat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] rdy_pat;
    logic any_done;

    // {load, op, rd, rs1, rs2, imm, expected rd value, expected status}
    mk(vecs[0],  1, OP_ADD,  1, 0, 0, 8'h7F, 8'h7F, 4'b0000);
    mk(vecs[1],  1, OP_ADD,  2, 0, 0, 8'h01, 8'h01, 4'b0000);
    mk(vecs[2],  0, OP_ADD,  3, 1, 2, 8'hEE, 8'h80, 4'b0011);
    mk(vecs[3],  0, OP_SUB,  0, 2, 2, 8'h00, 8'h00, 4'b1100);
    mk(vecs[4],  1, OP_SUB,  1, 3, 3, 8'h81, 8'h81, 4'b1100);
    mk(vecs[5],  0, OP_SHL,  1, 1, 0, 8'h00, 8'h02, 4'b1000);
    mk(vecs[6],  0, OP_AND,  2, 3, 1, 8'h00, 8'h00, 4'b0100);
    mk(vecs[7],  0, OP_XOR,  0, 3, 1, 8'h00, 8'h82, 4'b0001);
    mk(vecs[8],  0, OP_ADD,  2, 0, 0, 8'h00, 8'h04, 4'b1010);
    mk(vecs[9],  0, OP_SUB,  3, 1, 3, 8'h00, 8'h82, 4'b0011);
    mk(vecs[10], 0, OP_OR,   1, 2, 3, 8'h00, 8'h86, 4'b0001);
    mk(vecs[11], 0, OP_SHR,  0, 1, 1, 8'h00, 8'h43, 4'b0000);

    rst = 1'b1; clr_sticky = 1'b0; dbg_addr = '0;
    cif.cmd_valid = 1'b0; cif.cmd_load = 1'b0; cif.cmd_op = '0;
    cif.cmd_rd = '0; cif.cmd_rs1 = '0; cif.cmd_rs2 = '0; cif.cmd_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;

    // Reset state
    chk("rst_cmd_ready", cif.cmd_ready, 1'b1);
    chk("rst_status", status, 4'b0000);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_v_sticky", v_sticky, 1'b0);
    chk("rst_alu_a", alu_a, 8'h00);
    for (int a = 0; a < NREG; a++) begin
      dbg_addr = a[1:0]; #1;
      chk($sformatf("rst_dbg_r%0d", a), dbg_data, 8'h00);
    end

    // Table-driven command sequence
    for (int i = 0; i < 12; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // cmd_valid held high for 8 cycles: accepted only at edges 0 and 4
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_load = 1'b1; cif.cmd_op = OP_ADD;
    cif.cmd_rd = 2'd2; cif.cmd_rs1 = 2'd0; cif.cmd_rs2 = 2'd0; cif.cmd_imm = 8'h55;
    for (int i = 0; i < 8; i++) begin
      rdy_pat[i] = cif.cmd_ready;
      @(negedge clk);
    end
    cif.cmd_valid = 1'b0;
    chk("hold_valid_ready_pattern", rdy_pat, 8'b0001_0001);
    repeat (4) @(negedge clk);
    dbg_addr = 2'd2; #1;
    chk("hold_valid_r2", dbg_data, 8'h55);
    chk("hold_valid_idle", cif.cmd_ready, 1'b1);

    // Reset during EXEC of ADD r3: no done pulse, no write
    mk(v, 1, OP_ADD, 1, 0, 0, 8'h7F, 8'h7F, 4'b0000);
    run_cmd(v, "pre_rst_ld_r1");
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_load = 1'b0; cif.cmd_op = OP_ADD;
    cif.cmd_rd = 2'd3; cif.cmd_rs1 = 2'd1; cif.cmd_rs2 = 2'd2; cif.cmd_imm = 8'h00;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    any_done = 1'b0;
    @(negedge clk);          // OPER
    any_done |= done;
    @(negedge clk);          // EXEC
    any_done |= done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      any_done |= done;
      @(negedge clk);
    end
    chk("rst_exec_no_done", any_done, 1'b0);
    dbg_addr = 2'd3; #1;
    chk("rst_exec_r3", dbg_data, 8'h00);
    chk("rst_exec_status", status, 4'b0000);
    chk("rst_exec_ready", cif.cmd_ready, 1'b1);

    // Sticky overflow behaviour (tied low when the feature is absent)
    mk(v, 1, OP_ADD, 1, 0, 0, 8'h7F, 8'h7F, 4'b0000); run_cmd(v, "stk_ld_r1");
    mk(v, 1, OP_ADD, 2, 0, 0, 8'h01, 8'h01, 4'b0000); run_cmd(v, "stk_ld_r2");
    mk(v, 0, OP_ADD, 3, 1, 2, 8'h00, 8'h80, 4'b0011); run_cmd(v, "stk_add");
    chk("sticky_after_add_v1", v_sticky, STICKY);
    mk(v, 0, OP_SUB, 0, 2, 2, 8'h00, 8'h00, 4'b1100); run_cmd(v, "stk_sub");
    chk("sticky_hold_sub_v0", v_sticky, STICKY);
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    chk("sticky_cleared", v_sticky, 1'b0);
    clr_sticky = 1'b1;
    mk(v, 0, OP_ADD, 3, 1, 2, 8'h00, 8'h80, 4'b0011); run_cmd(v, "stk_add_clr");
    chk("sticky_set_beats_clear", v_sticky, STICKY);
    clr_sticky = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
